// File: rtl/binary_mac_acc_5_1_bi_if.sv
// Purpose : handshake/data bundle between the product source, the MAC accumulator and the result sink.
// Latency : none; this file holds wiring only.
// Backpressure: in_ready gates the product stream and out_ready holds the result.
// Ports   : clear/start/prod_in/prod_valid/out_ready are driven toward the accumulator;
//           in_ready/acc_out/out_valid/busy/term_cnt/overflow come back from it.
interface binary_mac_acc_5_1_bi_if #(
   parameter int PW    = 9,
   parameter int ACC_W = 16,
   parameter int CNT_W = 4
);
   logic             clear;
   logic             start;
   logic [PW-1:0]    prod_in;
   logic             prod_valid;
   logic             in_ready;
   logic [ACC_W-1:0] acc_out;
   logic             out_valid;
   logic             out_ready;
   logic             busy;
   logic [CNT_W-1:0] term_cnt;
   logic             overflow;

   // Side that feeds products and consumes results.
   modport master (
      output clear, start, prod_in, prod_valid, out_ready,
      input  in_ready, acc_out, out_valid, busy, term_cnt, overflow
   );

   // Accumulator side.
   modport slave (
      input  clear, start, prod_in, prod_valid, out_ready,
      output in_ready, acc_out, out_valid, busy, term_cnt, overflow
   );
endinterface

// File: rtl/binary_mac_acc_5_1_bi.sv
// Purpose : accumulates N_TERMS signed products into one dot-product result, with optional saturation.
// Latency : out_valid rises 1 clock after the N_TERMS-th accepted product.
// Backpressure: the result is held in HOLD until out_ready; in_ready is low outside ACCUM.
// Ports   : clk, rst_n (async, active-low); bus (slave side of binary_mac_acc_5_1_bi_if).
//           All outputs come from registers or are decoded from the state register only.
module binary_mac_acc_5_1_bi #(
   parameter int PW      = 9,
   parameter int N_TERMS = 8,
   parameter int ACC_W   = 16,
   parameter int SAT     = 1,
   parameter int CNT_W   = $clog2(N_TERMS) + 1
) (
   input  logic                     clk,
   input  logic                     rst_n,
   binary_mac_acc_5_1_bi_if.slave   bus
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ACCUM = 2'd1,
      S_HOLD  = 2'd2
   } state_t;

   localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
   localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

   state_t            r_state;
   state_t            w_state_nxt;
   logic [ACC_W-1:0]  r_acc;
   logic [ACC_W-1:0]  w_acc_nxt;
   logic [CNT_W-1:0]  r_cnt;
   logic [CNT_W-1:0]  w_cnt_nxt;
   logic              r_ovf;
   logic              w_ovf_nxt;

   logic [ACC_W:0]    w_sum;
   logic              w_sum_ovf;
   logic              w_accept;
   logic              w_last;

   // One guard bit: both operands are sign-extended to ACC_W+1, so the sum
   // cannot wrap and overflow is visible as a mismatch of the top two bits.
   assign w_sum     = {r_acc[ACC_W-1], r_acc}
                    + {{(ACC_W+1-PW){bus.prod_in[PW-1]}}, bus.prod_in};
   assign w_sum_ovf = w_sum[ACC_W] ^ w_sum[ACC_W-1];
   assign w_accept  = (r_state == S_ACCUM) && bus.prod_valid;
   assign w_last    = (r_cnt == CNT_W'(N_TERMS - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_acc   <= '0;
         r_cnt   <= '0;
         r_ovf   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_acc   <= w_acc_nxt;
         r_cnt   <= w_cnt_nxt;
         r_ovf   <= w_ovf_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_acc_nxt   = r_acc;
      w_cnt_nxt   = r_cnt;
      w_ovf_nxt   = r_ovf;

      case (r_state)
         S_IDLE: begin
            if (bus.start) begin
               w_state_nxt = S_ACCUM;
               w_acc_nxt   = '0;
               w_cnt_nxt   = '0;
               w_ovf_nxt   = 1'b0;
            end
         end
         S_ACCUM: begin
            if (w_accept) begin
               w_cnt_nxt = r_cnt + CNT_W'(1);
               if (w_sum_ovf) begin
                  w_ovf_nxt = 1'b1;
                  // The sum's true sign is its guard bit; clamping feeds
                  // later products from the clamped value.
                  if (SAT != 0) begin
                     w_acc_nxt = w_sum[ACC_W] ? ACC_MIN : ACC_MAX;
                  end else begin
                     w_acc_nxt = w_sum[ACC_W-1:0];
                  end
               end else begin
                  w_acc_nxt = w_sum[ACC_W-1:0];
               end
               if (w_last) begin
                  w_state_nxt = S_HOLD;
               end
            end
         end
         S_HOLD: begin
            if (bus.out_ready) begin
               if (bus.start) begin
                  // Back-to-back: the next accumulation opens on the transfer edge.
                  w_state_nxt = S_ACCUM;
                  w_acc_nxt   = '0;
                  w_cnt_nxt   = '0;
                  w_ovf_nxt   = 1'b0;
               end else begin
                  w_state_nxt = S_IDLE;
               end
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase

      // Synchronous abort beats every other request in the same cycle.
      if (bus.clear) begin
         w_state_nxt = S_IDLE;
         w_acc_nxt   = '0;
         w_cnt_nxt   = '0;
         w_ovf_nxt   = 1'b0;
      end
   end

   assign bus.in_ready  = (r_state == S_ACCUM);
   assign bus.out_valid = (r_state == S_HOLD);
   assign bus.busy      = (r_state != S_IDLE);
   assign bus.acc_out   = r_acc;
   assign bus.term_cnt  = r_cnt;
   assign bus.overflow  = r_ovf;

endmodule
